mem_io_unit: RTL

MEM_IO_UNIT -- requirements
Module: mem_io_unit

---
 rtl/mem_io_unit.sv | 137 +++++++++++++
 1 files changed

// File: rtl/mem_io_unit.sv
// mem_io_unit: word-addressed RAM with four memory-mapped byte I/O registers
// at the top of the address space.
//
// Ports:
//   clk, reset           clock (rising edge) and async active-high reset
//   i_addr, i_data       CPU word address and write data
//   i_ce, i_we           access strobe and write enable (one access per cycle)
//   o_data               registered read data (1-cycle latency, holds between reads)
//   i_in_valid/i_in_data/o_in_ready    valid/ready byte source feeding a 2-entry FIFO
//   o_out_valid/o_out_data/i_out_ready valid/ready byte sink driven by OUT_DATA writes
//
// I/O map (top four words): +0 IN_DATA (R), +1 IN_STATUS (R),
//                           +2 OUT_DATA (R/W), +3 OUT_STATUS (R)
module mem_io_unit #(
   parameter int DWIDTH     = 16,
   parameter int ADDR_WIDTH = 12
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic [DWIDTH-1:0]     i_data,
   input  logic                  i_we,
   input  logic                  i_ce,
   output logic [DWIDTH-1:0]     o_data,
   input  logic                  i_in_valid,
   input  logic [7:0]            i_in_data,
   output logic                  o_in_ready,
   output logic                  o_out_valid,
   output logic [7:0]            o_out_data,
   input  logic                  i_out_ready
);

   localparam int DEPTH = 2**ADDR_WIDTH;

   logic [DWIDTH-1:0] mem [DEPTH];

   logic              io_hit;
   logic [1:0]        io_reg;
   logic              rd_en;
   logic              wr_en;
   logic [1:0]        in_count;
   logic [7:0]        in_q0;
   logic [7:0]        in_q1;
   logic              overrun;
   logic              push;
   logic              pop;
   logic              out_wr;
   logic              out_accept;
   logic              out_drop;
   logic              stat_rd;
   logic [DWIDTH-1:0] io_word;

   // The I/O window is the last four words, so the RAM array never sees them.
   assign io_hit = &i_addr[ADDR_WIDTH-1:2];
   assign io_reg = i_addr[1:0];
   assign rd_en  = i_ce & ~i_we;
   assign wr_en  = i_ce & i_we;

   assign o_in_ready = (in_count < 2'd2);
   assign push       = i_in_valid & o_in_ready;
   assign pop        = rd_en & io_hit & (io_reg == 2'd0) & (in_count != 2'd0);

   // A write into an occupied output slot only lands if the sink drains it
   // in the same cycle; otherwise the byte is lost and flagged.
   assign out_wr     = wr_en & io_hit & (io_reg == 2'd2);
   assign out_accept = out_wr & (~o_out_valid | i_out_ready);
   assign out_drop   = out_wr & ~out_accept;
   assign stat_rd    = rd_en & io_hit & (io_reg == 2'd3);

   always_comb begin
      io_word = '0;
      case (io_reg)
         2'd0: io_word[7:0] = (in_count != 2'd0) ? in_q0 : 8'h00;
         2'd1: io_word[1:0] = in_count;
         2'd2: io_word[7:0] = o_out_data;
         2'd3: io_word[1:0] = {overrun, o_out_valid};
      endcase
   end

   // RAM contents carry no reset.
   always_ff @(posedge clk) begin
      if (wr_en && !io_hit) begin
         mem[i_addr] <= i_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         o_data <= '0;
      end else if (rd_en) begin
         o_data <= io_hit ? io_word : mem[i_addr];
      end
   end

   // in_q0 is always the head; a pop shifts in_q1 down.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         in_count <= 2'd0;
         in_q0    <= 8'h00;
         in_q1    <= 8'h00;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (in_count == 2'd0) in_q0 <= i_in_data;
               else                  in_q1 <= i_in_data;
               in_count <= in_count + 2'd1;
            end
            2'b01: begin
               in_q0    <= in_q1;
               in_count <= in_count - 2'd1;
            end
            // push+pop is only possible at count 1: the new byte becomes head
            2'b11: in_q0 <= i_in_data;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         o_out_valid <= 1'b0;
         o_out_data  <= 8'h00;
         overrun     <= 1'b0;
      end else begin
         if (out_accept) begin
            o_out_data  <= i_data[7:0];
            o_out_valid <= 1'b1;
         end else if (o_out_valid && i_out_ready) begin
            o_out_valid <= 1'b0;
         end
         // A new overrun outranks the clear-on-read of OUT_STATUS.
         if (out_drop)     overrun <= 1'b1;
         else if (stat_rd) overrun <= 1'b0;
      end
   end

endmodule
